// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low gfedcba patterns and the all-off code.
// Hex letter patterns are only decoded when SEG7_HEX_EN is defined.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational 4-bit code to active-low gfedcba segment decoder.
// SEG7_HEX_EN enables A-F letters; otherwise codes 10-15 light nothing.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_OFF;
        case (code)
            4'd0:  seg_n = SEG_0;
            4'd1:  seg_n = SEG_1;
            4'd2:  seg_n = SEG_2;
            4'd3:  seg_n = SEG_3;
            4'd4:  seg_n = SEG_4;
            4'd5:  seg_n = SEG_5;
            4'd6:  seg_n = SEG_6;
            4'd7:  seg_n = SEG_7;
            4'd8:  seg_n = SEG_8;
            4'd9:  seg_n = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10: seg_n = SEG_A;
            4'd11: seg_n = SEG_B;
            4'd12: seg_n = SEG_C;
            4'd13: seg_n = SEG_D;
            4'd14: seg_n = SEG_E;
            4'd15: seg_n = SEG_F;
`endif
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with shadowed display data, leading-zero
// suppression and a one-cycle dead time between slots. Hex letters via SEG7_HEX_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

    logic                    tick;
    logic [NUM_DIGITS-1:0]   suppress;
    logic                    zero_above;
    logic [3:0]              sel_code;
    logic                    sel_dp;
    logic                    sel_suppress;
    logic [NUM_DIGITS-1:0]   sel_an_n;
    logic [6:0]              dec_seg_n;

    assign tick = (tick_cnt_q == CNT_W'(SCAN_DIV - 1));

    // Walk from the top digit down so zero_above covers digits i..NUM_DIGITS-1.
    always_comb begin
        suppress   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (shadow_digits_q[i*4 +: 4] == 4'd0);
            suppress[i] = shadow_blank_q[i] | (lz_en & (i > 0) & zero_above);
        end
    end

    always_comb begin
        sel_code     = 4'd0;
        sel_dp       = 1'b0;
        sel_suppress = 1'b0;
        sel_an_n     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_code     = shadow_digits_q[i*4 +: 4];
                sel_dp       = shadow_dp_q[i];
                sel_suppress = suppress[i];
                sel_an_n[i]  = 1'b0;
            end
        end
    end

    seg7_digit_decode u_decode (
        .code  (sel_code),
        .seg_n (dec_seg_n)
    );

    always_comb begin
        tick_cnt_d      = tick ? '0 : tick_cnt_q + CNT_W'(1);
        idx_d           = idx_q;
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        shadow_blank_d  = shadow_blank_q;
        seg_n_d         = SEG_OFF;
        dp_n_d          = 1'b1;
        an_n_d          = '1;

        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            shadow_digits_d = digits;
            shadow_dp_d     = dp;
            shadow_blank_d  = blank;
        end
        // The tick edge is the dead-time cycle; suppressed slots stay dark but still elapse.
        if (!tick && !sel_suppress) begin
            seg_n_d = dec_seg_n;
            dp_n_d  = ~sel_dp;
            an_n_d  = sel_an_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q      <= '0;
            idx_q           <= '0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            shadow_blank_q  <= '0;
            seg_n_q         <= SEG_OFF;
            dp_n_q          <= 1'b1;
            an_n_q          <= '1;
        end else begin
            tick_cnt_q      <= tick_cnt_d;
            idx_q           <= idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            shadow_blank_q  <= shadow_blank_d;
            seg_n_q         <= seg_n_d;
            dp_n_q          <= dp_n_d;
            an_n_q          <= an_n_d;
        end
    end

    assign seg_n = seg_n_q;
    assign dp_n  = dp_n_q;
    assign an_n  = an_n_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clocks per digit slot, legal minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port load, input, 1: capture strobe for digits, dp and blank.
REQ-006 SHALL have port digits, input, 4*NUM_DIGITS: packed codes; digit 0 in bits [3:0] and least significant.
REQ-007 SHALL have port dp, input, NUM_DIGITS: decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank, input, NUM_DIGITS: per-digit force-off mask, 1 = off.
REQ-009 SHALL have port lz_en, input, 1: leading-zero suppression enable; live, not captured.
REQ-010 SHALL have port seg_n, output, 7: segments gfedcba, active-low, registered.
REQ-011 SHALL have port dp_n, output, 1: decimal point, active-low, registered.
REQ-012 SHALL have port an_n, output, NUM_DIGITS: digit enables, active-low, registered, at most one low.

Function
REQ-013 SHALL copy digits, dp and blank into shadow registers on every edge with load=1; display SHALL use only the shadow registers.
REQ-014 SHALL keep tick_cnt counting 0..SCAN_DIV-1 and wrapping; tick = (tick_cnt == SCAN_DIV-1).
REQ-015 SHALL keep scan index idx; on tick, idx increments, wrapping from NUM_DIGITS-1 to 0.
REQ-016 SHALL, on the edge where tick=1, register an_n all-ones, seg_n 7'h7F and dp_n 1 (one-cycle dead time).
REQ-017 SHALL, on all other edges, register an_n with only bit idx low, seg_n = decode(shadow[idx]) and dp_n = ~shadow_dp[idx].
REQ-018 SHALL drive codes 0-9 active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL suppress digit i when shadow_blank[i]=1, or when lz_en=1, i>0, and digits i..NUM_DIGITS-1 are all zero.
REQ-020 SHALL drive a suppressed digit's slot with an_n all-ones and dp_n 1, while still advancing through the slot normally.
REQ-021 SHALL, when load and tick coincide, give the newly captured shadow priority for the slot entered on the following edge.
REQ-022 SHALL behave correctly when NUM_DIGITS=1: idx constant 0, and the dead-time cycle is still inserted every SCAN_DIV clocks.

Reset
REQ-023 SHALL, on an edge with rst=1, set tick_cnt=0, idx=0, all shadow registers 0, seg_n=7'h7F, dp_n=1 and an_n all-ones, regardless of scan state.
REQ-024 SHALL restart the scan from digit 0 on the first edge after rst deasserts, at tick_cnt=0.

Configuration
REQ-025 SHALL, with SEG7_HEX_EN defined, decode codes 10-15 as A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 SHALL, without SEG7_HEX_EN, decode codes 10-15 as 1111111 with the digit's anode still enabled.

Structure
REQ-027 SHALL place the segment pattern constants and the SEG_OFF constant (7'h7F) in shared package seg7_pkg.
REQ-028 SHALL implement decoding in one combinational sub-module, seg7_digit_decode (4-bit code in, 7-bit seg_n out), instantiated once on the idx-selected code.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-029 SHALL check reset: rst=1 for 2 cycles -> seg_n=7'h7F, dp_n=1, an_n=4'b1111.
REQ-030 SHALL check scan order: load digits=16'h1234, lz_en=0 -> an_n=1110 with seg_n=0011001, then one all-ones cycle, then 1101 with 0110000, then digits 2 and 3, then wrap to 1110.
REQ-031 SHALL check leading-zero suppression: digits=16'h0070, lz_en=1 -> digit 3 and digit 2 slots all-ones, digit 1 slot seg_n=1111000, digit 0 slot seg_n=1000000.
REQ-032 SHALL check hex decode: digits[3:0]=4'hB -> seg_n=0000011 with SEG7_HEX_EN; seg_n=1111111 and an_n=1110 without it.
REQ-033 SHALL check load/tick collision: load digits=16'h0009 on the tick edge entering digit 0 -> next cycle seg_n=0010000.
REQ-034 SHALL check reset mid-scan: assert rst while idx=2 -> next edge gives all-ones outputs; after release, first slot is an_n=1110.
